// File: rtl/k10_md_ctrl.sv
// k10_md_ctrl: issue/retire controller between the pipeline and a
// multi-cycle mul/div unit. Holds one op in flight, registers the
// result for a downstream valid/ready handshake, and drains the
// divider back to idle before it may be restarted.

package komandara_k10_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

endpackage

module k10_md_ctrl
    import komandara_k10_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    // upstream issue
    input  logic         i_valid,
    output logic         o_ready,
    input  md_op_e       i_op,
    input  logic [31:0]  i_a,
    input  logic [31:0]  i_b,
    input  logic [4:0]   i_rd,
    input  logic         i_flush,
    // mul/div unit
    output logic         o_md_start,
    output md_op_e       o_md_op,
    output logic [31:0]  o_md_a,
    output logic [31:0]  o_md_b,
    input  logic         i_md_busy,
    input  logic         i_md_done,
    input  logic [31:0]  i_md_result,
    // downstream result
    output logic         o_valid,
    input  logic         i_ready,
    output logic [31:0]  o_result,
    output logic [4:0]   o_rd
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DRAIN
    } state_e;

    state_e      state;
    logic [4:0]  rd_q;
    logic        is_div;

    // Divide-class ops leave the unit in a DONE state that must be drained.
    always_comb begin
        is_div = o_md_op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    end

    // Accept only when idle and the result slot is free or being freed now.
    always_comb begin
        o_ready = i_rst_n && (state == IDLE) && (!o_valid || i_ready) && !i_flush;
    end

    // Control FSM with registered unit request, operands and result.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            o_md_start <= 1'b0;
            o_md_op    <= MD_MUL;
            o_md_a     <= '0;
            o_md_b     <= '0;
            rd_q       <= '0;
            o_valid    <= 1'b0;
            o_result   <= '0;
            o_rd       <= '0;
        end else begin
            // Consume first; a capture below in the same cycle overrides it.
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        o_md_op    <= i_op;
                        o_md_a     <= i_a;
                        o_md_b     <= i_b;
                        rd_q       <= i_rd;
                        o_md_start <= 1'b1;
                        state      <= EXEC;
                    end
                end

                EXEC: begin
                    // Flush wins over a same-cycle done; the held result is older and kept.
                    if (i_flush || i_md_done) begin
                        if (!i_flush) begin
                            o_result <= i_md_result;
                            o_rd     <= rd_q;
                            o_valid  <= 1'b1;
                        end
                        o_md_start <= 1'b0;
                        state      <= is_div ? DRAIN : IDLE;
                    end
                end

                DRAIN: begin
                    if (!i_md_busy && !i_md_done) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state      <= IDLE;
                    o_md_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_k10_md_ctrl.sv
// Testbench for k10_md_ctrl: behavioural mul/div unit (combinational
// multiply, 32-iteration divide), directed latency/flush/reset scenarios
// and a scoreboard of expected results retired on the result handshake.

module tb_k10_md_ctrl;
    import komandara_k10_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_valid;
    logic         o_ready;
    md_op_e       i_op;
    logic [31:0]  i_a;
    logic [31:0]  i_b;
    logic [4:0]   i_rd;
    logic         i_flush;
    logic         o_md_start;
    md_op_e       o_md_op;
    logic [31:0]  o_md_a;
    logic [31:0]  o_md_b;
    logic         md_busy;
    logic         md_done;
    logic [31:0]  md_result;
    logic         o_valid;
    logic         i_ready;
    logic [31:0]  o_result;
    logic [4:0]   o_rd;

    always #5 clk = ~clk;

    k10_md_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_op        (i_op),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_rd        (i_rd),
        .i_flush     (i_flush),
        .o_md_start  (o_md_start),
        .o_md_op     (o_md_op),
        .o_md_a      (o_md_a),
        .o_md_b      (o_md_b),
        .i_md_busy   (md_busy),
        .i_md_done   (md_done),
        .i_md_result (md_result),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_rd        (o_rd)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic is_div_op(input md_op_e op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    // RISC-V M-extension reference results.
    function automatic logic [31:0] md_ref(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, pr;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ea  = {32'b0, a};
        eb  = {32'b0, b};
        if (op == MD_MULH || op == MD_MULHSU) ea = {{32{a[31]}}, a};
        if (op == MD_MULH) eb = {{32{b[31]}}, b};
        pr = ea * eb;
        case (op)
            MD_MUL:    return pr[31:0];
            MD_MULH,
            MD_MULHSU,
            MD_MULHU:  return pr[63:32];
            MD_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MD_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Behavioural unit: multiply answers in the start cycle; divide runs
    // 32 busy cycles, then sits in DONE until start is dropped.
    typedef enum {U_IDLE, U_BUSY, U_DONE} ust_e;
    ust_e        ust;
    int          ucnt;
    logic [31:0] ures;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            ust  <= U_IDLE;
            ucnt <= 0;
        end else begin
            case (ust)
                U_IDLE: if (o_md_start && is_div_op(o_md_op)) begin
                    ust  <= U_BUSY;
                    ucnt <= 0;
                    ures <= md_ref(o_md_op, o_md_a, o_md_b);
                end
                U_BUSY: if (ucnt == 31) ust <= U_DONE; else ucnt <= ucnt + 1;
                default: if (!o_md_start) ust <= U_IDLE;
            endcase
        end
    end

    assign md_busy   = (ust == U_BUSY);
    assign md_done   = (ust == U_DONE) || (ust == U_IDLE && o_md_start && !is_div_op(o_md_op));
    assign md_result = (ust == U_DONE) ? ures : md_ref(o_md_op, o_md_a, o_md_b);

    // Retire monitor: every handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", o_result, e.res);
                chk("rd", 32'(o_rd), 32'(e.rd));
                if (e.lat != 0) chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg(input int t);
        @(negedge clk);
        while (cyc < t) @(negedge clk);
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after accept.
    task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic push, input logic [31:0] exp,
                         input int lat, output int acc);
        exp_t e;
        acc     = -1;
        i_valid = 1'b1;
        i_op    = op;
        i_a     = a;
        i_b     = b;
        i_rd    = rd;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (o_ready) begin
                acc = cyc;
                break;
            end
            step();
        end
        if (acc < 0) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else if (push) begin
            e.res = exp; e.rd = rd; e.lat = lat; e.acc = acc;
            sb.push_back(e);
        end
        step();
        i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200 && sb.size() != 0; n++) step();
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int acc;
        int t_rdy;
        md_op_e op;
        logic [31:0] ra, rb;

        rst_n = 1'b0; i_valid = 1'b0; i_op = MD_MUL; i_a = '0; i_b = '0;
        i_rd = '0; i_flush = 1'b0; i_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_start", 32'(o_md_start), 32'd0);
        chk("rst_result", o_result, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // MUL 7*6: result two cycles after accept, ready again at once
        issue(MD_MUL, 32'd7, 32'd6, 5'd9, 1'b1, 32'd42, 2, acc);
        at_neg(acc + 2);
        chk("mul_valid", 32'(o_valid), 32'd1);
        chk("mul_result", o_result, 32'd42);
        chk("mul_ready", 32'(o_ready), 32'd1);
        step();

        // DIV -20/3: start held A+1..A+34, result at A+35
        issue(MD_DIV, 32'hFFFF_FFEC, 32'd3, 5'd4, 1'b1, 32'hFFFF_FFFA, 35, acc);
        for (int k = 1; k <= 35; k++) begin
            at_neg(acc + k);
            chk("div_start", 32'(o_md_start), (k <= 34) ? 32'd1 : 32'd0);
            if (k == 20) chk("div_opnd_a", o_md_a, 32'hFFFF_FFEC);
        end
        chk("div_valid", 32'(o_valid), 32'd1);
        step();

        // DIVU then REMU back-to-back with downstream stalled
        wait_drain();
        i_ready = 1'b0;
        issue(MD_DIVU, 32'd100, 32'd7, 5'd5, 1'b1, 32'd14, 0, acc);
        i_valid = 1'b1; i_op = MD_REMU; i_a = 32'd100; i_b = 32'd7; i_rd = 5'd6;
        at_neg(acc + 35);
        chk("stall_valid", 32'(o_valid), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            at_neg(acc + 35 + k);
            chk("stall_ready", 32'(o_ready), 32'd0);
            chk("stall_hold", o_result, 32'd14);
        end
        step();
        i_ready = 1'b1;
        at_neg(acc + 40);
        chk("stall_accept", 32'(o_ready), 32'd1);
        begin
            exp_t e;
            e.res = 32'd2; e.rd = 5'd6; e.lat = 0; e.acc = acc + 40;
            sb.push_back(e);
        end
        step();
        i_valid = 1'b0;

        // divide by zero
        issue(MD_DIVU, 32'd5, 32'd0, 5'd1, 1'b1, 32'hFFFF_FFFF, 35, acc);
        issue(MD_REMU, 32'd5, 32'd0, 5'd2, 1'b1, 32'd5, 35, acc);

        // flush a divide mid-flight
        issue(MD_DIV, 32'd1000, 32'd7, 5'd3, 1'b0, 32'd0, 0, acc);
        at_neg(acc + 9);
        step();
        i_flush = 1'b1;
        at_neg(acc + 10);
        chk("flush_ready", 32'(o_ready), 32'd0);
        step();
        i_flush = 1'b0;
        at_neg(acc + 11);
        chk("flush_start", 32'(o_md_start), 32'd0);
        t_rdy = -1;
        for (int n = 0; n < 60; n++) begin
            if (o_ready) begin
                t_rdy = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("flush_idle_cyc", 32'(t_rdy - acc), 32'd36);
        step();
        issue(MD_MUL, 32'd3, 32'd3, 5'd8, 1'b1, 32'd9, 2, acc);

        // mixed ops
        for (int i = 0; i < 8; i++) begin
            op = md_op_e'(i);
            ra = $urandom;
            rb = (i == 6) ? 32'd0 : $urandom;
            issue(op, ra, rb, 5'(i + 10), 1'b1, md_ref(op, ra, rb), is_div_op(op) ? 35 : 2, acc);
        end
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 1'b1, 32'h8000_0000, 35, acc);

        // reset in the middle of a divide
        wait_drain();
        issue(MD_DIV, 32'h1234, 32'h56, 5'd7, 1'b0, 32'd0, 0, acc);
        at_neg(acc + 4);
        step();
        rst_n = 1'b0;
        at_neg(acc + 6);
        chk("mrst_valid", 32'(o_valid), 32'd0);
        chk("mrst_start", 32'(o_md_start), 32'd0);
        chk("mrst_ready", 32'(o_ready), 32'd0);
        chk("mrst_a", o_md_a, 32'd0);
        chk("mrst_b", o_md_b, 32'd0);
        chk("mrst_result", o_result, 32'd0);
        chk("mrst_rd", 32'(o_rd), 32'd0);
        chk("mrst_op", 32'(o_md_op), 32'(MD_MUL));
        step();
        rst_n = 1'b1;
        step();
        issue(MD_MUL, 32'd2, 32'd5, 5'd11, 1'b1, 32'd10, 2, acc);

        wait_drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
